// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer
//   Packs committed USB payload bytes into 128-bit blocks for an AES core.
//   The first complete block after reset is loaded as the key. Every later
//   block is launched with aes_start, and the ciphertext is latched on
//   data_out with a one-cycle complete pulse. Bytes of a packet that ends
//   with an error are rolled back to the last good packet boundary.
//
// Handshakes:
//   rx_byte_valid and rx_pkt_end are one-cycle strobes. A byte is taken only
//   while rx_ready is high and the block is not full; any other strobed byte
//   is dropped and sets the sticky overflow flag. aes_start is a one-cycle
//   launch pulse. aes_done is a one-cycle result strobe that is honoured only
//   while the sequencer is waiting for the core.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rx_data/rx_byte_valid        received byte and its strobe
//   rx_pkt_end/rx_pkt_err        end-of-packet strobe and its error flag
//   rx_ready                     high while bytes are accepted
//   key_out/key_load             key register and its update pulse
//   aes_data/aes_start           plaintext block and launch pulse
//   aes_done/aes_result          core result strobe and ciphertext
//   data_out/complete            latched ciphertext and its valid pulse
//   overflow/timeout             sticky error flags
//   state_dbg                    current FSM state, for observation only
module aes_block_sequencer #(
  parameter int BLOCK_BYTES = 16,
  parameter int AES_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_byte_valid,
  input  logic         rx_pkt_end,
  input  logic         rx_pkt_err,
  output logic         rx_ready,
  output logic [127:0] key_out,
  output logic         key_load,
  output logic [127:0] aes_data,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_result,
  output logic [127:0] data_out,
  output logic         complete,
  output logic         overflow,
  output logic         timeout,
  output logic [2:0]   state_dbg
);

  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam int TW = $clog2(AES_TIMEOUT);

  typedef enum logic [2:0] {
    KEY_FILL  = 3'd0,
    DATA_FILL = 3'd1,
    START     = 3'd2,
    WAIT      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   byte_cnt, commit_cnt, cnt_inc;
  logic [TW-1:0]   timer;
  logic [127:0]    buffer, buffer_next;
  logic            fill, accept, drop, good_commit, bad_commit, block_full;
  logic            timer_expire;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= KEY_FILL;
    else     state <= state_next;
  end

  always_comb begin
    fill         = (state == KEY_FILL) || (state == DATA_FILL);
    accept       = fill && rx_byte_valid && (byte_cnt != CW'(BLOCK_BYTES));
    drop         = rx_byte_valid && !accept;
    cnt_inc      = accept ? byte_cnt + CW'(1) : byte_cnt;
    // Commit/rollback sees the count after this cycle's byte.
    good_commit  = fill && rx_pkt_end && !rx_pkt_err;
    bad_commit   = fill && rx_pkt_end && rx_pkt_err;
    block_full   = good_commit && (cnt_inc == CW'(BLOCK_BYTES));
    // A done on the expiry cycle wins over the timeout.
    timer_expire = (state == WAIT) && !aes_done && (timer == TW'(AES_TIMEOUT - 1));

    buffer_next = buffer;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (accept && (byte_cnt == CW'(i)))
        buffer_next[8*(BLOCK_BYTES-1-i) +: 8] = rx_data;
    end

    state_next = state;
    case (state)
      KEY_FILL:  if (block_full) state_next = DATA_FILL;
      DATA_FILL: if (block_full) state_next = START;
      START:     state_next = WAIT;
      WAIT: begin
        if (aes_done)          state_next = DONE;
        else if (timer_expire) state_next = DATA_FILL;
      end
      DONE:      state_next = DATA_FILL;
      default:   state_next = KEY_FILL;
    endcase

    rx_ready  = fill;
    aes_start = (state == START);
    complete  = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= '0;
      commit_cnt <= '0;
      timer      <= '0;
      buffer     <= '0;
      key_out    <= '0;
      key_load   <= 1'b0;
      aes_data   <= '0;
      data_out   <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      key_load <= 1'b0;
      if (drop) overflow <= 1'b1;
      case (state)
        KEY_FILL, DATA_FILL: begin
          buffer <= buffer_next;
          if (block_full) begin
            byte_cnt   <= '0;
            commit_cnt <= '0;
            if (state == KEY_FILL) begin
              key_out  <= buffer_next;
              key_load <= 1'b1;
            end else begin
              aes_data <= buffer_next;
            end
          end else if (good_commit) begin
            byte_cnt   <= cnt_inc;
            commit_cnt <= cnt_inc;
          end else if (bad_commit) begin
            byte_cnt <= commit_cnt;
          end else begin
            byte_cnt <= cnt_inc;
          end
        end
        START: begin
          byte_cnt   <= '0;
          commit_cnt <= '0;
          timer      <= '0;
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (aes_done)          data_out <= aes_result;
          else if (timer_expire) timeout  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
module tb_aes_block_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_byte_valid, rx_pkt_end, rx_pkt_err;
  logic         rx_ready;
  logic [127:0] key_out;
  logic         key_load;
  logic [127:0] aes_data;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_result;
  logic [127:0] data_out;
  logic         complete, overflow, timeout;
  logic [2:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int complete_cnt = 0;
  int start_snap;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] BLK1 = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] BLK2 = 128'hA1A2A4505152535455565758595A5B5C;
  localparam logic [127:0] BLK3 = 128'h606162636465666768696A6B6C6D6E6F;
  localparam logic [127:0] KEY2 = 128'h808182838485868788898A8B8C8D8E8F;
  localparam logic [127:0] RES1 = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
  localparam logic [127:0] RES2 = 128'h0123456789ABCDEF0011223344556677;
  localparam logic [127:0] RES3 = 128'hFFEEDDCCBBAA99887766554433221100;

  aes_block_sequencer #(.BLOCK_BYTES(16), .AES_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_byte_valid(rx_byte_valid),
    .rx_pkt_end(rx_pkt_end), .rx_pkt_err(rx_pkt_err),
    .rx_ready(rx_ready),
    .key_out(key_out), .key_load(key_load),
    .aes_data(aes_data), .aes_start(aes_start),
    .aes_done(aes_done), .aes_result(aes_result),
    .data_out(data_out), .complete(complete),
    .overflow(overflow), .timeout(timeout),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (aes_start) start_cnt++;
    if (complete)  complete_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic pend, input logic perr);
    rx_data       = b;
    rx_byte_valid = 1'b1;
    rx_pkt_end    = pend;
    rx_pkt_err    = perr;
    tick();
    rx_byte_valid = 1'b0;
    rx_pkt_end    = 1'b0;
    rx_pkt_err    = 1'b0;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " key_out"},   key_out,   '0);
    check({tag, " key_load"},  {127'd0, key_load},  '0);
    check({tag, " aes_data"},  aes_data,  '0);
    check({tag, " aes_start"}, {127'd0, aes_start}, '0);
    check({tag, " data_out"},  data_out,  '0);
    check({tag, " complete"},  {127'd0, complete},  '0);
    check({tag, " overflow"},  {127'd0, overflow},  '0);
    check({tag, " timeout"},   {127'd0, timeout},   '0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pkt_end;
    logic       exp_ready;
    logic       exp_key_load;
    logic       exp_start;
  } vec_t;

  vec_t vecs[32];

  initial begin
    // vector table: 16 one-byte key packets, then a data block in 4-byte packets
    for (int i = 0; i < 16; i++) begin
      vecs[i].data         = 8'(i);
      vecs[i].pkt_end      = 1'b1;
      vecs[i].exp_ready    = 1'b1;
      vecs[i].exp_key_load = (i == 15);
      vecs[i].exp_start    = 1'b0;
    end
    for (int i = 16; i < 32; i++) begin
      vecs[i].data         = 8'(8'h10 + (i - 16));
      vecs[i].pkt_end      = ((i - 16) % 4 == 3);
      vecs[i].exp_ready    = (i != 31);
      vecs[i].exp_key_load = 1'b0;
      vecs[i].exp_start    = (i == 31);
    end

    rst = 1'b1; rx_data = '0; rx_byte_valid = 1'b0; rx_pkt_end = 1'b0;
    rx_pkt_err = 1'b0; aes_done = 1'b0; aes_result = '0;
    ticks(2);
    rst = 1'b0;
    check_all_zero("reset");
    check("reset rx_ready", {127'd0, rx_ready}, 128'd1);

    // key load and first data block
    for (int i = 0; i < 32; i++) begin
      send(vecs[i].data, vecs[i].pkt_end, 1'b0);
      check($sformatf("vec%0d rx_ready", i), {127'd0, rx_ready}, {127'd0, vecs[i].exp_ready});
      check($sformatf("vec%0d key_load", i), {127'd0, key_load}, {127'd0, vecs[i].exp_key_load});
      check($sformatf("vec%0d aes_start", i), {127'd0, aes_start}, {127'd0, vecs[i].exp_start});
      if (i == 15) begin
        check("key_out", key_out, KEY1);
        check("no start during key", 128'(start_cnt), 128'd0);
      end
    end
    check("aes_data blk1", aes_data, BLK1);

    // encrypt: core answers 10 cycles after start
    tick();
    check("wait aes_start low", {127'd0, aes_start}, '0);
    check("wait rx_ready low", {127'd0, rx_ready}, '0);
    ticks(9);
    aes_done = 1'b1; aes_result = RES1;
    tick();
    aes_done = 1'b0;
    check("complete pulse", {127'd0, complete}, 128'd1);
    check("data_out res1", data_out, RES1);
    tick();
    check("complete one cycle", {127'd0, complete}, '0);
    check("back to fill", {127'd0, rx_ready}, 128'd1);

    // rollback: A3 is discarded, A4 takes its place
    send(8'hA1, 1'b1, 1'b0);
    send(8'hA2, 1'b1, 1'b0);
    send(8'hA3, 1'b1, 1'b1);
    send(8'hA4, 1'b1, 1'b0);
    for (int k = 0; k < 13; k++) send(8'(8'h50 + k), (k == 12), 1'b0);
    check("rollback start", {127'd0, aes_start}, 128'd1);
    check("rollback aes_data", aes_data, BLK2);
    check("rollback top bytes", {104'd0, aes_data[127:104]}, 128'hA1A2A4);
    check("no overflow yet", {127'd0, overflow}, '0);

    // busy drop: byte during WAIT
    tick();
    send(8'hEE, 1'b0, 1'b0);
    check("busy overflow", {127'd0, overflow}, 128'd1);
    check("busy rx_ready", {127'd0, rx_ready}, '0);
    ticks(2);
    aes_done = 1'b1; aes_result = RES2;
    tick();
    aes_done = 1'b0;
    check("complete 2", {127'd0, complete}, 128'd1);
    check("data_out res2", data_out, RES2);
    tick();

    // next block must start at byte 0
    for (int k = 0; k < 16; k++) send(8'(8'h60 + k), (k == 15), 1'b0);
    check("blk3 start", {127'd0, aes_start}, 128'd1);
    check("blk3 aes_data", aes_data, BLK3);

    // timeout: 64 cycles in WAIT without done
    tick();
    ticks(63);
    check("pre-timeout flag", {127'd0, timeout}, '0);
    check("pre-timeout ready", {127'd0, rx_ready}, '0);
    tick();
    check("timeout flag", {127'd0, timeout}, 128'd1);
    check("timeout ready", {127'd0, rx_ready}, 128'd1);
    check("timeout no complete", {127'd0, complete}, '0);
    aes_done = 1'b1; aes_result = RES3;
    tick();
    aes_done = 1'b0;
    check("late done no complete", {127'd0, complete}, '0);
    check("late done data_out", data_out, RES2);
    check("complete count", 128'(complete_cnt), 128'd2);
    check("overflow sticky", {127'd0, overflow}, 128'd1);
    tick();

    // reset during WAIT with a coincident aes_done
    for (int k = 0; k < 16; k++) send(8'(8'h70 + k), (k == 15), 1'b0);
    check("blk4 start", {127'd0, aes_start}, 128'd1);
    ticks(4);
    rst = 1'b1; aes_done = 1'b1; aes_result = RES3;
    tick();
    rst = 1'b0; aes_done = 1'b0;
    check_all_zero("midwait rst");
    check("midwait rst ready", {127'd0, rx_ready}, 128'd1);
    tick();
    check("post rst no complete", {127'd0, complete}, '0);
    start_snap = start_cnt;
    for (int k = 0; k < 16; k++) send(8'(8'h80 + k), (k == 15), 1'b0);
    check("rekey key_load", {127'd0, key_load}, 128'd1);
    check("rekey key_out", key_out, KEY2);
    check("rekey no start", {127'd0, aes_start}, '0);
    tick();
    check("rekey key_load pulse", {127'd0, key_load}, '0);
    check("rekey start count", 128'(start_cnt), 128'(start_snap));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
